switch_debounce_filter: RTL and testbench
=========================================

SWITCH_DEBOUNCE_FILTER -- requirements
Module: switch_debounce_filter

Interface
REQ-001: Parameter DEBOUNCE_LIMIT, default 250000, SHALL set the number of consecutive clocks a new level must hold before acceptance (10 ms at 25 MHz); legal range 2..2^24.
REQ-002: Parameter RESET_LEVEL, default 0, SHALL set the reset value of the filtered level.
REQ-003: i_Clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-004: i_Rst  input  1  asynchronous, active-high reset.
REQ-005: i_Switch  input  1  raw, asynchronous, bouncing switch level.
REQ-006: o_Switch  output  1  debounced switch level, registered.
REQ-007: o_Press  output  1  one-clock pulse when o_Switch goes 0->1.
REQ-008: o_Release  output  1  one-clock pulse when o_Switch goes 1->0.
REQ-009: o_Toggle  output  1  present only with SWITCH_DEBOUNCE_TOGGLE_EN (see Configuration).

Function
REQ-010: i_Switch SHALL pass through a 2-flop synchronizer; no other logic SHALL sample i_Switch directly.
REQ-011: Counter width SHALL be $clog2(DEBOUNCE_LIMIT); the counter SHALL never wrap past DEBOUNCE_LIMIT-1.
REQ-012: If synchronized level equals o_Switch, counter SHALL clear to 0 on that clock.
REQ-013: If synchronized level differs from o_Switch and counter < DEBOUNCE_LIMIT-1, counter SHALL increment by 1.
REQ-014: If synchronized level differs and counter == DEBOUNCE_LIMIT-1, o_Switch SHALL take the synchronized level and counter SHALL clear to 0 on the same clock.
REQ-015: Latency: for an input held stable, o_Switch SHALL change on rising edge DEBOUNCE_LIMIT+2, counting the first edge that samples the new level as edge 1.
REQ-016: Any return of the synchronized level to o_Switch before acceptance SHALL discard the partial count (no accumulation across bounces).
REQ-017: o_Press/o_Release SHALL assert in the same clock o_Switch changes, for exactly one clock, and SHALL never assert together.
REQ-018: A new opposite transition SHALL require a full fresh DEBOUNCE_LIMIT window; back-to-back events SHALL be at least DEBOUNCE_LIMIT clocks apart.

Reset
REQ-019: On i_Rst high, immediately and independent of i_Clk: synchronizer flops and o_Switch SHALL equal RESET_LEVEL, counter 0, o_Press 0, o_Release 0, o_Toggle 0.
REQ-020: Deassertion SHALL produce no o_Press/o_Release pulse, even if i_Switch differs from RESET_LEVEL; such a level SHALL be accepted only via the normal window (REQ-015), then pulse normally.
REQ-021: Reset mid-window SHALL discard the partial count.

Configuration
REQ-022: Macro SWITCH_DEBOUNCE_TOGGLE_EN defined: o_Toggle SHALL exist, reset to 0, and invert on the clock o_Release asserts (toggle on release).
REQ-023: Macro undefined: o_Toggle port and its register SHALL be absent; all other behaviour identical.

Verification (DEBOUNCE_LIMIT=4, RESET_LEVEL=0, 10 ns clock)
REQ-024: Reset held, i_Switch=1 -> o_Switch=0, o_Press=0, o_Release=0, o_Toggle=0 throughout reset and with no pulse at deassertion.
REQ-025: i_Switch 0->1 held stable -> o_Switch=1 and o_Press=1 for one clock on edge 6 after first sampling edge; counter back to 0.
REQ-026: i_Switch bounce 1 for 3 clocks, 0 for 1, then 1 stable -> no early change; o_Switch rises exactly 6 edges after the final 0->1 sample.
REQ-027: From o_Switch=1, i_Switch 1->0 stable -> o_Release=1 one clock on edge 6; with SWITCH_DEBOUNCE_TOGGLE_EN, o_Toggle 0->1; second press/release cycle returns o_Toggle to 0.
REQ-028: i_Rst pulsed asynchronously (between clock edges) when counter=2 -> outputs reset immediately, no pulse; after release, full 6-edge window required.
REQ-029: Glitch of 1 clock on i_Switch during stable level -> o_Switch, o_Press, o_Release unchanged.

Source files
------------

// File: rtl/switch_debounce_filter.sv
// Debounces a raw switch level: 2-flop synchronizer, then a hold-time counter before acceptance.
// Optional: define SWITCH_DEBOUNCE_TOGGLE_EN to add o_Toggle, which flips on every release.
module switch_debounce_filter #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter logic        RESET_LEVEL    = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  output logic o_Toggle,
`endif
  output logic o_Release
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

  logic [1:0]      sync_q;
  logic            sync_lvl;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sw_q, sw_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // Only this flop touches the asynchronous input.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q <= {2{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[0], i_Switch};
    end
  end

  assign sync_lvl = sync_q[1];

  // A level must differ from the accepted one on DEBOUNCE_LIMIT consecutive clocks;
  // any agreeing clock restarts the window from zero.
  always_comb begin
    cnt_d     = '0;
    sw_d      = sw_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_lvl != sw_q) begin
      if (cnt_q == CntMax) begin
        sw_d      = sync_lvl;
        press_d   = sync_lvl;
        release_d = ~sync_lvl;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q     <= '0;
      sw_q      <= RESET_LEVEL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_Switch  = sw_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic toggle_q, toggle_d;

  assign toggle_d = toggle_q ^ release_d;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign o_Toggle = toggle_q;
`endif

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Bench for switch_debounce_filter: directed latency/bounce/reset cases plus random stimulus
// checked every cycle against a sliding-window model of the debounce rule.
module tb_switch_debounce_filter;

  localparam int unsigned Limit  = 4;
  localparam logic        RstLvl = 1'b0;

  logic i_Clk    = 1'b0;
  logic i_Rst    = 1'b1;
  logic i_Switch = 1'b1;
  logic o_Switch, o_Press, o_Release;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic o_Toggle;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the level seen by the filter lags the pin by two clocks; a new level is accepted
  // once the last Limit filter-visible samples all differ from the accepted level.
  logic m_sw    = RstLvl;
  logic m_press = 1'b0;
  logic m_rel   = 1'b0;
  logic m_tog   = 1'b0;
  logic m_s1    = RstLvl;
  logic m_s2    = RstLvl;
  logic m_seen;
  logic m_all_diff;
  logic hist[$];

  switch_debounce_filter #(
    .DEBOUNCE_LIMIT(Limit),
    .RESET_LEVEL   (RstLvl)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Switch (i_Switch),
    .o_Switch (o_Switch),
    .o_Press  (o_Press),
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    .o_Toggle (o_Toggle),
`endif
    .o_Release(o_Release)
  );

  initial forever #5 i_Clk = ~i_Clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_edge;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_Clk);
      i_Switch = v;
      @(posedge i_Clk);
    end
  endtask

  initial forever begin
    @(posedge i_Clk or posedge i_Rst);
    if (i_Rst) begin
      m_sw = RstLvl; m_press = 1'b0; m_rel = 1'b0; m_tog = 1'b0;
      m_s1 = RstLvl; m_s2 = RstLvl;
      hist.delete();
    end else begin
      m_seen = m_s2;
      m_s2   = m_s1;
      m_s1   = i_Switch;
      hist.push_back(m_seen);
      if (hist.size() > Limit) void'(hist.pop_front());
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_all_diff = (hist.size() == Limit);
      foreach (hist[i]) if (hist[i] == m_sw) m_all_diff = 1'b0;
      if (m_all_diff) begin
        m_sw    = ~m_sw;
        m_press = m_sw;
        m_rel   = ~m_sw;
        if (m_rel) m_tog = ~m_tog;
        hist.delete();
      end
    end
  end

  initial forever begin
    @(negedge i_Clk);
    chk("model_switch", o_Switch, m_sw);
    chk("model_press", o_Press, m_press);
    chk("model_release", o_Release, m_rel);
    chk("press_release_exclusive", o_Press & o_Release, 1'b0);
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    chk("model_toggle", o_Toggle, m_tog);
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   left;
    logic v;

    // Reset held with the pin high: outputs stay at reset values.
    repeat (3) begin
      wait_edge;
      chk("rst_switch", o_Switch, 1'b0);
      chk("rst_press", o_Press, 1'b0);
      chk("rst_release", o_Release, 1'b0);
    end
    @(negedge i_Clk);
    i_Rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      wait_edge;
      chk("press_latency_sw", o_Switch, e >= 6);
      chk("press_latency_pulse", o_Press, e == 6);
      chk("press_latency_rel", o_Release, 1'b0);
    end

    hold(1'b1, 3);
    @(negedge i_Clk);
    i_Switch = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      wait_edge;
      chk("release_latency_sw", o_Switch, e < 6);
      chk("release_latency_pulse", o_Release, e == 6);
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      chk("toggle_first_release", o_Toggle, e >= 6);
`endif
    end

    // Bounce: 1,1,1,0 then 1 stable; acceptance counts from the final 0->1 sample (k=5).
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_Clk);
      i_Switch = (k == 4) ? 1'b0 : 1'b1;
      wait_edge;
      chk("bounce_sw", o_Switch, k >= 10);
      chk("bounce_press", o_Press, k == 10);
    end

    // Single-clock glitch while stable high.
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_Clk);
      i_Switch = (k == 3) ? 1'b0 : 1'b1;
      wait_edge;
      chk("glitch_sw", o_Switch, 1'b1);
      chk("glitch_press", o_Press, 1'b0);
      chk("glitch_release", o_Release, 1'b0);
    end

    hold(1'b0, 8);
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    #1 chk("toggle_second_release", o_Toggle, 1'b0);
`endif
    hold(1'b1, 8);

    // Asynchronous reset mid-window, counter at 2.
    @(negedge i_Clk);
    i_Switch = 1'b0;
    repeat (4) wait_edge;
    chk("pre_reset_sw", o_Switch, 1'b1);
    #1 i_Rst = 1'b1;
    #1;
    chk("async_rst_sw", o_Switch, 1'b0);
    chk("async_rst_release", o_Release, 1'b0);
    chk("async_rst_press", o_Press, 1'b0);
    i_Switch = 1'b1;
    #1 i_Rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      wait_edge;
      chk("post_rst_window_sw", o_Switch, e >= 6);
      chk("post_rst_window_press", o_Press, e == 6);
    end

    // Random segments with occasional asynchronous reset pulses.
    left = 0;
    v    = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (left == 0) begin
        v    = 1'($urandom_range(0, 1));
        left = int'($urandom_range(1, 10));
      end
      @(negedge i_Clk);
      i_Switch = v;
      left--;
      @(posedge i_Clk);
      if ($urandom_range(0, 199) == 0) begin
        #2 i_Rst = 1'b1;
        #1 i_Rst = 1'b0;
      end
    end

    @(negedge i_Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
